pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipeline. Each cycle it drives the state inputs (ENABLE/STALL/NOP) of the four inter-stage latches (fetch/decode, decode/exec, exec/mem, mem/wb) and the PC enable. It resolves instruction-cache misses, data-cache waits, load-use hazards, control redirects and halt, and it keeps stall and flush counters for performance visibility.

---
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: drives the four inter-stage latch commands and
// the PC enable from cache, hazard, redirect and halt conditions.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             redirect_ex,
  input  logic             MemRead_ex,
  input  logic [4:0]       regWSEL_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             halt_wb,
  output logic [1:0]       fd_state,
  output logic [1:0]       de_state,
  output logic [1:0]       em_state,
  output logic [1:0]       mw_state,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] PIPE_ENABLE = 2'd0;
  localparam logic [1:0] PIPE_STALL  = 2'd1;
  localparam logic [1:0] PIPE_NOP    = 2'd2;

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic dmem_stall, load_use, in_halt, flush_act;

  assign dmem_stall = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign load_use   = MemRead_ex & (regWSEL_ex != 5'd0) &
                      ((regWSEL_ex == rs_id) | (uses_rt_id & (regWSEL_ex == rt_id)));
  assign in_halt    = (state_q == HALT) | halt_wb;
  assign flush_act  = ~in_halt & ~dmem_stall & ihit & redirect_ex;

  // Priority chain: halt, data wait, fetch miss, redirect, load-use, run.
  always_comb begin
    fd_state = PIPE_ENABLE;
    de_state = PIPE_ENABLE;
    em_state = PIPE_ENABLE;
    mw_state = PIPE_ENABLE;
    pc_en    = 1'b1;
    if (in_halt) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_STALL;
      pc_en    = 1'b0;
    end else if (dmem_stall) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (!ihit) begin
      // MEM retires while EX (and any branch in it) is held for re-evaluation.
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (redirect_ex) begin
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
    end else if (load_use) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_NOP;
      pc_en    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_wb) state_d = HALT;
    else begin
      case (state_q)
        RUN:     if (dmem_stall) state_d = DWAIT;
        DWAIT:   if (dhit) state_d = RUN;
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_q | halt_wb;
      if (!pc_en && !in_halt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_act && (flush_cnt_q != '1))          flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: vector table plus hand sequences, scoreboard queue of
// expected latch commands popped on the falling edge.
module tb_pipeline_hazard_ctrl;

  logic CLK = 1'b0, nRST;
  logic ihit, dhit, dren, dwen, redir, memrd, uses_rt, halt;
  logic [4:0] wsel, rs, rt;
  logic [1:0] fd, de, em, mw, fd4, de4, em4, mw4;
  logic pc_en, halted, pc_en4, halted4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN_mem(dren),
    .dmemWEN_mem(dwen), .redirect_ex(redir), .MemRead_ex(memrd), .regWSEL_ex(wsel),
    .rs_id(rs), .rt_id(rt), .uses_rt_id(uses_rt), .halt_wb(halt),
    .fd_state(fd), .de_state(de), .em_state(em), .mw_state(mw), .pc_en(pc_en),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN_mem(dren),
    .dmemWEN_mem(dwen), .redirect_ex(redir), .MemRead_ex(memrd), .regWSEL_ex(wsel),
    .rs_id(rs), .rt_id(rt), .uses_rt_id(uses_rt), .halt_wb(halt),
    .fd_state(fd4), .de_state(de4), .em_state(em4), .mw_state(mw4), .pc_en(pc_en4),
    .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  // Expected {fd,de,em,mw,pc_en}
  localparam logic [8:0] E_RUN   = {2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
  localparam logic [8:0] E_HALT  = {2'd1, 2'd1, 2'd1, 2'd1, 1'b0};
  localparam logic [8:0] E_DMEM  = {2'd1, 2'd1, 2'd1, 2'd2, 1'b0};
  localparam logic [8:0] E_IMISS = {2'd1, 2'd1, 2'd2, 2'd0, 1'b0};
  localparam logic [8:0] E_REDIR = {2'd2, 2'd2, 2'd0, 2'd0, 1'b1};
  localparam logic [8:0] E_LU    = {2'd1, 2'd2, 2'd0, 2'd0, 1'b0};

  typedef struct {
    string      name;
    logic       ihit, dhit, dren, dwen, redir, memrd;
    logic [4:0] wsel, rs, rt;
    logic       uses_rt, halt;
    logic [8:0] exp;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int checks = 0, errors = 0;
  int exp_stall = 0, exp_flush = 0;
  logic model_halted = 1'b0;

  function automatic vec_t mk(input string n, input logic ih, dh, dr, dw, rd, mr,
                              input logic [4:0] ws, r_s, r_t, input logic ur, hl,
                              input logic [8:0] e);
    vec_t v;
    v.name = n; v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.redir = rd;
    v.memrd = mr; v.wsel = ws; v.rs = r_s; v.rt = r_t; v.uses_rt = ur; v.halt = hl;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; dren = v.dren; dwen = v.dwen; redir = v.redir;
    memrd = v.memrd; wsel = v.wsel; rs = v.rs; rt = v.rt; uses_rt = v.uses_rt;
    halt = v.halt;
  endtask

  // One cycle: drive, queue expectation, compare mid-cycle, advance past edge.
  task automatic step(input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(negedge CLK);
    e = sb.pop_front();
    chk(e.name, {23'd0, fd, de, em, mw, pc_en}, {23'd0, e.exp});
    if (!model_halted && !e.halt) begin
      if (!e.exp[0]) exp_stall++;
      if (e.exp == E_REDIR) exp_flush++;
    end
    if (e.halt) model_halted = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    drive(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    nRST = 1'b0;
    #2;
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {16'd0, flush_cnt}, 32'd0);
    chk("rst_outputs", {23'd0, fd, de, em, mw, pc_en}, {23'd0, E_RUN});
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_stall = 0; exp_flush = 0; model_halted = 1'b0;
  endtask

  vec_t idle;

  initial begin
    nRST = 1'b1;
    idle = mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    tbl.push_back(mk("lu_rs",      1, 0, 0, 0, 0, 1, 8, 8, 0, 0, 0, E_LU));
    tbl.push_back(mk("lu_r0",      1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, E_RUN));
    tbl.push_back(mk("lu_rt_nouse",1, 0, 0, 0, 0, 1, 8, 3, 8, 0, 0, E_RUN));
    tbl.push_back(mk("lu_rt_use",  1, 0, 0, 0, 0, 1, 8, 3, 8, 1, 0, E_LU));
    tbl.push_back(mk("no_load",    1, 0, 0, 0, 0, 0, 8, 8, 8, 1, 0, E_RUN));
    tbl.push_back(mk("redir_lu",   1, 0, 0, 0, 1, 1, 8, 8, 0, 0, 0, E_REDIR));
    tbl.push_back(mk("imiss",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IMISS));
    tbl.push_back(mk("dmem_imiss", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_DMEM));
    tbl.push_back(mk("dhit_imiss", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_IMISS));
    tbl.push_back(mk("store_wait", 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, E_DMEM));
    tbl.push_back(mk("store_done", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk("redir_only", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_REDIR));

    do_reset();
    for (int i = 0; i < 5; i++) step(idle);
    chk("idle_stall", {16'd0, stall_cnt}, 32'd0);

    foreach (tbl[i]) step(tbl[i]);
    chk("tbl_stall", {16'd0, stall_cnt}, exp_stall);
    chk("tbl_flush", {16'd0, flush_cnt}, exp_flush);
    chk("tbl_stall_const", {16'd0, stall_cnt}, 32'd6);

    // Data-cache wait: three stalled cycles, then completion.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(mk("dwait", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_DMEM));
      chk("fsm_dwait", {30'd0, dut.state_q}, 32'd1);
    end
    step(mk("dwait_done", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    chk("fsm_run", {30'd0, dut.state_q}, 32'd0);
    chk("dwait_stall", {16'd0, stall_cnt}, 32'd3);

    // Redirect held under a fetch miss, then taken once.
    do_reset();
    for (int i = 0; i < 2; i++) step(mk("redir_imiss", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_IMISS));
    step(mk("redir_go", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_REDIR));
    chk("redir_flush", {16'd0, flush_cnt}, 32'd1);
    chk("redir_stall", {16'd0, stall_cnt}, 32'd2);

    // Reset in the middle of a data wait.
    step(mk("dwait2", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_DMEM));
    #2 nRST = 1'b0;
    #1;
    chk("midrst_state", {30'd0, dut.state_q}, 32'd0);
    chk("midrst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("midrst_flush", {16'd0, flush_cnt}, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_stall = 0; exp_flush = 0; model_halted = 1'b0;

    // Halt: immediate freeze, sticky flag, frozen counters.
    step(mk("pre_halt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IMISS));
    step(mk("halt_wb", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HALT));
    chk("halted_rise", {31'd0, halted}, 32'd1);
    step(mk("halt_dmem", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT));
    step(mk("halt_redir", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_HALT));
    step(mk("halt_imiss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT));
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halt_stall_frozen", {16'd0, stall_cnt}, 32'd1);
    chk("halt_flush_frozen", {16'd0, flush_cnt}, 32'd0);
    do_reset();
    step(idle);
    chk("unhalt", {31'd0, halted}, 32'd0);

    // Saturation on the narrow instance.
    do_reset();
    for (int i = 0; i < 20; i++) step(mk("sat_imiss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IMISS));
    chk("sat_cnt4", {28'd0, stall_cnt4}, 32'hF);
    chk("sat_cnt16", {16'd0, stall_cnt}, 32'd20);
    chk("sat_model", {16'd0, stall_cnt}, exp_stall);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
